// File: rtl/i2c_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_port_arbiter
// Purpose  : Round-robin sharing of one I2C register-access controller among
//            NUM_REQ clients, with a per-transaction watchdog abort.
// Revision : 1.0
// ============================================================================
module i2c_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_REQ-1:0]     s_enable,
    input  logic [8*NUM_REQ-1:0]   s_reg_addr,
    input  logic [5*NUM_REQ-1:0]   s_reg_len,
    input  logic [8*NUM_REQ-1:0]   s_reg_wrdata,
    input  logic [NUM_REQ-1:0]     s_reg_rdwr,
    output logic [NUM_REQ-1:0]     s_done,
    output logic [NUM_REQ-1:0]     s_ack,
    output logic [7:0]             s_rddata,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   m_enable,
    output logic [7:0]             m_reg_addr,
    output logic [4:0]             m_reg_len,
    output logic [7:0]             m_reg_wrdata,
    output logic                   m_reg_rdwr,
    input  logic                   m_done,
    input  logic                   m_ack,
    input  logic [7:0]             m_rddata
);

    localparam int          c_IDX_W    = $clog2(NUM_REQ);
    localparam logic [23:0] c_CNT_LAST = 24'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state,    w_state;
    logic [NUM_REQ-1:0]   r_pending,  w_pending;
    logic [c_IDX_W-1:0]   r_last,     w_last;
    logic [c_IDX_W-1:0]   r_gidx,     w_gidx;
    logic [23:0]          r_cnt,      w_cnt;
    logic [NUM_REQ-1:0]   r_grant,    w_grant;
    logic                 r_busy,     w_busy;
    logic                 r_terr,     w_terr;
    logic                 r_m_enable, w_m_enable;
    logic [7:0]           r_m_addr,   w_m_addr;
    logic [4:0]           r_m_len,    w_m_len;
    logic [7:0]           r_m_wrdata, w_m_wrdata;
    logic                 r_m_rdwr,   w_m_rdwr;
    logic [NUM_REQ-1:0]   r_s_done,   w_s_done;
    logic [NUM_REQ-1:0]   r_s_ack,    w_s_ack;
    logic [7:0]           r_s_rddata, w_s_rddata;
    logic                 w_expire;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_pick;

    function automatic logic [c_IDX_W-1:0] rr_idx(input logic [c_IDX_W-1:0] base,
                                                   input int                 step);
        int t;
        t = (int'(base) + step) % NUM_REQ;
        return c_IDX_W'(t);
    endfunction

    // First pending client after the previous owner, wrapping modulo NUM_REQ.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && r_pending[rr_idx(r_last, k)]) begin
                w_found = 1'b1;
                w_pick  = rr_idx(r_last, k);
            end
        end
    end

    always_comb begin
        w_state    = r_state;
        w_pending  = r_pending;
        w_last     = r_last;
        w_gidx     = r_gidx;
        w_cnt      = r_cnt;
        w_grant    = r_grant;
        w_busy     = r_busy;
        w_terr     = r_terr;
        w_m_enable = 1'b0;
        w_m_addr   = r_m_addr;
        w_m_len    = r_m_len;
        w_m_wrdata = r_m_wrdata;
        w_m_rdwr   = r_m_rdwr;
        w_s_done   = '0;
        w_s_ack    = r_s_ack;
        w_s_rddata = r_s_rddata;
        w_expire   = (r_cnt == c_CNT_LAST);

        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_gidx          = w_pick;
                    w_grant         = '0;
                    w_grant[w_pick] = 1'b1;
                    w_m_addr        = s_reg_addr[8*w_pick +: 8];
                    w_m_len         = s_reg_len[5*w_pick +: 5];
                    w_m_wrdata      = s_reg_wrdata[8*w_pick +: 8];
                    w_m_rdwr        = s_reg_rdwr[w_pick];
                    w_m_enable      = 1'b1;
                    w_busy          = 1'b1;
                    w_cnt           = '0;
                    w_state         = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real completion in the expiry cycle takes precedence over the abort.
                if (m_done || w_expire) begin
                    w_s_done[r_gidx]  = 1'b1;
                    w_s_ack[r_gidx]   = m_done & m_ack;
                    w_s_rddata        = m_done ? m_rddata : 8'h00;
                    w_terr            = r_terr | ~m_done;
                    w_pending[r_gidx] = 1'b0;
                    w_last            = r_gidx;
                    w_grant           = '0;
                    w_busy            = 1'b0;
                    w_cnt             = '0;
                    w_state           = ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 24'd1;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        // New requests win over the completion clear of the same cycle.
        w_pending = w_pending | s_enable;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_last     <= c_IDX_W'(NUM_REQ - 1);
            r_gidx     <= '0;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_terr     <= 1'b0;
            r_m_enable <= 1'b0;
            r_m_addr   <= '0;
            r_m_len    <= '0;
            r_m_wrdata <= '0;
            r_m_rdwr   <= 1'b0;
            r_s_done   <= '0;
            r_s_ack    <= '0;
            r_s_rddata <= '0;
        end else begin
            r_state    <= w_state;
            r_pending  <= w_pending;
            r_last     <= w_last;
            r_gidx     <= w_gidx;
            r_cnt      <= w_cnt;
            r_grant    <= w_grant;
            r_busy     <= w_busy;
            r_terr     <= w_terr;
            r_m_enable <= w_m_enable;
            r_m_addr   <= w_m_addr;
            r_m_len    <= w_m_len;
            r_m_wrdata <= w_m_wrdata;
            r_m_rdwr   <= w_m_rdwr;
            r_s_done   <= w_s_done;
            r_s_ack    <= w_s_ack;
            r_s_rddata <= w_s_rddata;
        end
    end

    assign s_done       = r_s_done;
    assign s_ack        = r_s_ack;
    assign s_rddata     = r_s_rddata;
    assign grant        = r_grant;
    assign busy         = r_busy;
    assign timeout_err  = r_terr;
    assign m_enable     = r_m_enable;
    assign m_reg_addr   = r_m_addr;
    assign m_reg_len    = r_m_len;
    assign m_reg_wrdata = r_m_wrdata;
    assign m_reg_rdwr   = r_m_rdwr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_port_arbiter.sv
`default_nettype none
// Bench for i2c_port_arbiter: directed scenarios and randomized client and
// controller traffic, checked every cycle against a transaction-level model.
module tb_i2c_port_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic [N-1:0]     s_enable = '0;
    logic [8*N-1:0]   s_reg_addr = '0;
    logic [5*N-1:0]   s_reg_len = '0;
    logic [8*N-1:0]   s_reg_wrdata = '0;
    logic [N-1:0]     s_reg_rdwr = '0;
    logic [N-1:0]     s_done, s_ack, grant;
    logic [7:0]       s_rddata;
    logic             busy, timeout_err, m_enable;
    logic [7:0]       m_reg_addr, m_reg_wrdata;
    logic [4:0]       m_reg_len;
    logic             m_reg_rdwr;
    logic             m_done = 1'b0;
    logic             m_ack = 1'b0;
    logic [7:0]       m_rddata = '0;

    always #5 clk = ~clk;

    i2c_port_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn),
        .s_enable(s_enable), .s_reg_addr(s_reg_addr), .s_reg_len(s_reg_len),
        .s_reg_wrdata(s_reg_wrdata), .s_reg_rdwr(s_reg_rdwr),
        .s_done(s_done), .s_ack(s_ack), .s_rddata(s_rddata),
        .grant(grant), .busy(busy), .timeout_err(timeout_err),
        .m_enable(m_enable), .m_reg_addr(m_reg_addr), .m_reg_len(m_reg_len),
        .m_reg_wrdata(m_reg_wrdata), .m_reg_rdwr(m_reg_rdwr),
        .m_done(m_done), .m_ack(m_ack), .m_rddata(m_rddata)
    );

    // Client request fields
    logic [7:0] c_addr [N];
    logic [4:0] c_len  [N];
    logic [7:0] c_wr   [N];
    logic       c_rdwr [N];

    // Reference model state
    int           mdl_pend [N];
    int           mdl_last, mdl_owner, mdl_cnt;
    bit           mdl_busy, mdl_compl;
    logic [N-1:0] e_grant, e_done, e_ack;
    logic [7:0]   e_rddata, e_addr, e_wr;
    logic [4:0]   e_len;
    logic         e_rdwr, e_busy, e_men, e_terr;

    int errors = 0;
    int checks = 0;
    int n_men  = 0;
    int n_done = 0;
    int ctl_cd = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < N; i++) mdl_pend[i] = 0;
        mdl_last = N - 1; mdl_owner = 0; mdl_cnt = 0; mdl_busy = 0; mdl_compl = 0;
        e_grant = '0; e_done = '0; e_ack = '0; e_rddata = '0; e_addr = '0; e_wr = '0;
        e_len = '0; e_rdwr = 1'b0; e_busy = 1'b0; e_men = 1'b0; e_terr = 1'b0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs sampled there.
    task automatic mdl_edge(input logic [N-1:0] en, input bit md, input bit mack,
                            input logic [7:0] mrd);
        int p;
        e_done = '0; e_men = 1'b0; mdl_compl = 0;
        if (!mdl_busy) begin
            p = -1;
            for (int k = 1; k <= N; k++)
                if (p < 0 && mdl_pend[(mdl_last + k) % N] != 0) p = (mdl_last + k) % N;
            if (p >= 0) begin
                mdl_owner = p; mdl_busy = 1; mdl_cnt = 0;
                e_grant = '0; e_grant[p] = 1'b1; e_busy = 1'b1; e_men = 1'b1;
                e_addr = c_addr[p]; e_len = c_len[p]; e_wr = c_wr[p]; e_rdwr = c_rdwr[p];
            end
        end else if (md || mdl_cnt == TO - 1) begin
            e_done[mdl_owner] = 1'b1;
            e_ack[mdl_owner]  = md ? mack : 1'b0;
            e_rddata          = md ? mrd : 8'h00;
            if (!md) e_terr = 1'b1;
            mdl_pend[mdl_owner] = 0; mdl_last = mdl_owner;
            mdl_busy = 0; e_grant = '0; e_busy = 1'b0; mdl_cnt = 0; mdl_compl = 1;
        end else begin
            mdl_cnt++;
        end
        for (int i = 0; i < N; i++) if (en[i]) mdl_pend[i] = 1;
    endtask

    task automatic compare_all();
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("m_enable", 32'(m_enable), 32'(e_men));
        chk("s_done", 32'(s_done), 32'(e_done));
        chk("s_ack", 32'(s_ack), 32'(e_ack));
        chk("s_rddata", 32'(s_rddata), 32'(e_rddata));
        chk("timeout_err", 32'(timeout_err), 32'(e_terr));
        chk("m_fields", 32'({m_reg_rdwr, m_reg_wrdata, m_reg_len, m_reg_addr}),
                        32'({e_rdwr, e_wr, e_len, e_addr}));
    endtask

    task automatic cyc(input logic [N-1:0] en, input bit md, input bit mack,
                       input logic [7:0] mrd);
        @(negedge clk);
        s_enable = en; m_done = md; m_ack = mack; m_rddata = mrd;
        for (int i = 0; i < N; i++) begin
            s_reg_addr[8*i +: 8]   = c_addr[i];
            s_reg_len[5*i +: 5]    = c_len[i];
            s_reg_wrdata[8*i +: 8] = c_wr[i];
            s_reg_rdwr[i]          = c_rdwr[i];
        end
        @(posedge clk);
        mdl_edge(en, md, mack, mrd);
        #1;
        compare_all();
        if (m_enable) n_men++;
        if (|s_done) n_done++;
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic run_to_grant(input logic [N-1:0] en, output int g, output int n);
        g = -1; n = 0;
        for (int k = 0; k < 40; k++) begin
            cyc((k == 0) ? en : '0, 1'b0, 1'b0, 8'h00);
            n = k + 1;
            if (m_enable) begin
                g = idx_of(grant);
                break;
            end
        end
        if (g < 0) chk("grant_wait", 32'd0, 32'd1);
    endtask

    task automatic set_client(input int i, input logic [7:0] a, input logic [4:0] l,
                              input logic [7:0] w, input logic rw);
        c_addr[i] = a; c_len[i] = l; c_wr[i] = w; c_rdwr[i] = rw;
    endtask

    int g, n, k, base;
    logic [N-1:0] en;
    bit md, mack, fin, active;
    logic [7:0] mrd;
    int lat;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) set_client(i, 8'h00, 5'h00, 8'h00, 1'b0);
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;

        // Single request from client 1
        set_client(1, 8'hF4, 5'd3, 8'h27, 1'b0);
        cyc(3'b010, 0, 0, 8'h00);
        cyc(3'b000, 0, 0, 8'h00);
        chk("single_men", 32'(m_enable), 32'd1);
        chk("single_addr", 32'(m_reg_addr), 32'hF4);
        chk("single_len", 32'(m_reg_len), 32'd3);
        chk("single_wr", 32'(m_reg_wrdata), 32'h27);
        cyc(3'b000, 1, 1, 8'h00);
        chk("single_done", 32'(s_done), 32'b010);
        chk("single_ack", 32'(s_ack), 32'b010);

        // Contention between clients 0 and 1, each re-requesting after its s_done
        set_client(0, 8'h10, 5'd1, 8'h11, 1'b0);
        cyc(3'b011, 0, 0, 8'h00);
        en = '0;
        for (int t = 0; t < 4; t++) begin
            run_to_grant(en, g, n);
            chk("rr_order", 32'(g), 32'(t % 2));
            cyc(3'b000, 1, 1, 8'h00);
            en = '0;
            if (t < 3 && g >= 0) en[g] = 1'b1;
        end
        run_to_grant('0, g, n);
        cyc(3'b000, 1, 0, 8'h00);

        // Read data from client 0
        set_client(0, 8'h20, 5'd1, 8'h00, 1'b1);
        cyc(3'b001, 0, 0, 8'h00);
        run_to_grant('0, g, n);
        cyc(3'b000, 1, 1, 8'hA5);
        chk("rd_data", 32'(s_rddata), 32'hA5);
        chk("rd_done", 32'(s_done), 32'b001);
        repeat (3) cyc(3'b000, 0, 0, 8'h00);
        chk("rd_hold", 32'(s_rddata), 32'hA5);

        // Duplicate enable while pending gives one transaction
        base = n_men;
        cyc(3'b001, 0, 0, 8'h00);
        cyc(3'b001, 0, 0, 8'h00);
        cyc(3'b000, 1, 1, 8'h01);
        repeat (4) cyc(3'b000, 0, 0, 8'h00);
        chk("dup_txn", 32'(n_men - base), 32'd1);

        // Enable on own completion cycle gives a second transaction
        cyc(3'b001, 0, 0, 8'h00);
        run_to_grant('0, g, n);
        cyc(3'b001, 1, 1, 8'h02);
        run_to_grant('0, g, n);
        chk("regrant_client", 32'(g), 32'd0);
        cyc(3'b000, 1, 1, 8'h03);

        // m_done on the expiry cycle is a normal completion
        cyc(3'b010, 0, 0, 8'h00);
        run_to_grant('0, g, n);
        repeat (TO - 1) cyc(3'b000, 0, 0, 8'h00);
        cyc(3'b000, 1, 1, 8'h3C);
        chk("exp_done", 32'(s_done), 32'b010);
        chk("exp_ack", 32'(s_ack[1]), 32'd1);
        chk("exp_terr", 32'(timeout_err), 32'd0);

        // Watchdog abort, then the other pending client is served
        set_client(2, 8'h77, 5'd7, 8'h55, 1'b1);
        cyc(3'b101, 0, 0, 8'h00);
        run_to_grant('0, g, n);
        chk("wd_first", 32'(g), 32'd2);
        k = 0;
        for (int j = 0; j < 40; j++) begin
            cyc(3'b000, 0, 0, 8'h00);
            k = j + 1;
            if (|s_done) break;
        end
        chk("wd_latency", 32'(k), 32'(TO));
        chk("wd_done", 32'(s_done), 32'b100);
        chk("wd_ack", 32'(s_ack[2]), 32'd0);
        chk("wd_terr", 32'(timeout_err), 32'd1);
        run_to_grant('0, g, n);
        chk("wd_next", 32'(g), 32'd0);
        chk("wd_next_delay", 32'(n), 32'd1);
        cyc(3'b000, 1, 1, 8'h44);

        // Randomized traffic with a behavioural controller
        ctl_cd = 0;
        for (int t = 0; t < 3000; t++) begin
            md   = (ctl_cd == 1);
            mack = 1'($urandom);
            mrd  = 8'($urandom);
            if (!mdl_busy && ctl_cd == 0 && $urandom_range(0, 19) == 0) md = 1;
            fin = mdl_busy && (md || mdl_cnt == TO - 1);
            en = '0;
            for (int i = 0; i < N; i++) begin
                active = (mdl_pend[i] != 0) || (mdl_busy && mdl_owner == i);
                if (!active) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_client(i, 8'($urandom), 5'($urandom), 8'($urandom), 1'($urandom));
                        en[i] = 1'b1;
                    end
                end else if (fin && mdl_owner == i) begin
                    en[i] = 1'($urandom);
                end else if (mdl_pend[i] != 0 && $urandom_range(0, 9) == 0) begin
                    en[i] = 1'b1;
                end
            end
            cyc(en, md, mack, mrd);
            if (ctl_cd > 0) ctl_cd--;
            if (mdl_compl) ctl_cd = 0;
            if (e_men) begin
                lat = $urandom_range(0, 9);
                ctl_cd = (lat < 1) ? 0 : (lat < 3) ? TO : int'($urandom_range(1, 8));
            end
        end
        for (int t = 0; t < 200; t++) begin
            if (!mdl_busy && mdl_pend[0] == 0 && mdl_pend[1] == 0 && mdl_pend[2] == 0) break;
            cyc('0, 1'b1, 1'b1, 8'h5A);
        end
        chk("drain_idle", 32'(busy), 32'd0);

        // Asynchronous reset while busy
        set_client(1, 8'h99, 5'd2, 8'h66, 1'b0);
        cyc(3'b010, 0, 0, 8'h00);
        run_to_grant('0, g, n);
        repeat (3) cyc(3'b000, 0, 0, 8'h00);
        @(negedge clk);
        s_enable = '0; m_done = 1'b0; m_ack = 1'b0; m_rddata = '0;
        #2 rstn = 1'b0;
        #1;
        mdl_reset();
        compare_all();
        chk("rst_outputs", 32'({grant, busy, m_enable, timeout_err, s_ack, s_rddata}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        base = n_men; k = n_done;
        repeat (6) cyc(3'b000, 0, 0, 8'h00);
        chk("post_rst_men", 32'(n_men - base), 32'd0);
        chk("post_rst_done", 32'(n_done - k), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
